// File: rtl/gearbox_rx_if.sv
// Lane receive bundle between the SerDes word stream and the PCS RX.
// Carries slip_cnt_o only when GEARBOX_RX_SLIP_CNT_EN is defined.
interface gearbox_rx_if #(
    parameter int IN_W   = 32,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
);
    logic              in_v_i;
    logic [IN_W-1:0]   in_data_i;
    logic              slip_i;
    logic              valid_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;
`ifdef GEARBOX_RX_SLIP_CNT_EN
    logic [7:0]        slip_cnt_o;

    modport master (
        output in_v_i, in_data_i, slip_i,
        input  valid_o, head_o, data_o, slip_cnt_o
    );
    modport slave (
        input  in_v_i, in_data_i, slip_i,
        output valid_o, head_o, data_o, slip_cnt_o
    );
`else
    modport master (
        output in_v_i, in_data_i, slip_i,
        input  valid_o, head_o, data_o
    );
    modport slave (
        input  in_v_i, in_data_i, slip_i,
        output valid_o, head_o, data_o
    );
`endif
endinterface

// File: rtl/gearbox_rx.sv
// Per-lane RX gearbox: packs IN_W-bit SerDes words into 66-bit blocks.
// Optional applied-slip counter enabled by GEARBOX_RX_SLIP_CNT_EN.
module gearbox_rx #(
    parameter int IN_W   = 32,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input logic         clk,
    input logic         nreset,
    gearbox_rx_if.slave bus
);
    localparam int BLOCK_W = HEAD_W + DATA_W;
    localparam int BUF_W   = BLOCK_W + IN_W - 1;
    localparam int CNT_W   = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] bits_q, bits_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             slip_pend, slip_pend_n;

    logic [BUF_W-1:0] app_bits, slip_bits;
    logic [CNT_W-1:0] app_cnt, slip_cnt;
    logic             slip_req, do_slip, emit;

    always_comb begin
        app_bits = bits_q;
        app_cnt  = cnt_q;
        if (bus.in_v_i) begin
            app_bits = bits_q | (BUF_W'(bus.in_data_i) << cnt_q);
            app_cnt  = cnt_q + CNT_W'(IN_W);
        end

        // A slip with no bits buffered waits for the next bit to arrive
        slip_req    = bus.slip_i || slip_pend;
        do_slip     = slip_req && (app_cnt != '0);
        slip_pend_n = slip_req && (app_cnt == '0);
        slip_bits   = app_bits;
        slip_cnt    = app_cnt;
        if (do_slip) begin
            slip_bits = app_bits >> 1;
            slip_cnt  = app_cnt - 1'b1;
        end

        emit   = (slip_cnt >= CNT_W'(BLOCK_W));
        bits_n = slip_bits;
        cnt_n  = slip_cnt;
        if (emit) begin
            bits_n = slip_bits >> BLOCK_W;
            cnt_n  = slip_cnt - CNT_W'(BLOCK_W);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bits_q      <= '0;
            cnt_q       <= '0;
            slip_pend   <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.head_o  <= '0;
            bus.data_o  <= '0;
        end else begin
            bits_q      <= bits_n;
            cnt_q       <= cnt_n;
            slip_pend   <= slip_pend_n;
            bus.valid_o <= emit;
            if (emit) begin
                bus.head_o <= slip_bits[HEAD_W-1:0];
                bus.data_o <= slip_bits[BLOCK_W-1:HEAD_W];
            end
        end
    end

`ifdef GEARBOX_RX_SLIP_CNT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.slip_cnt_o <= '0;
        end else if (do_slip && (bus.slip_cnt_o != 8'hff)) begin
            bus.slip_cnt_o <= bus.slip_cnt_o + 8'd1;
        end
    end
`endif
endmodule
